// File: rtl/morse_pkg.sv
// Shared definitions for the Morse digit decoder: FSM encoding, symbol values
// and the ten five-symbol digit codes (first symbol at bit 4).
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_GAP    = 2'd2,
    ST_DECODE = 2'd3
  } state_e;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int MORSE_SYMS = 5;
  localparam int NUM_DIGITS = 10;

  // Index 9 is the leftmost element of the concatenation.
  localparam logic [NUM_DIGITS-1:0][MORSE_SYMS-1:0] DIGIT_CODES = {
    5'b11110,  // 9
    5'b11100,  // 8
    5'b11000,  // 7
    5'b10000,  // 6
    5'b00000,  // 5
    5'b00001,  // 4
    5'b00011,  // 3
    5'b00111,  // 2
    5'b01111,  // 1
    5'b11111   // 0
  };

endpackage

// File: rtl/morse_code_lut.sv
// Combinational pattern-to-digit lookup; valid_o is low for any pattern that
// is not one of the ten digit codes.
module morse_code_lut
  import morse_pkg::*;
(
  input  logic [MORSE_SYMS-1:0] pattern_i,
  output logic [3:0]            digit_o,
  output logic                  valid_o
);

  logic [NUM_DIGITS-1:0] hit;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_match
    assign hit[gi] = (pattern_i == DIGIT_CODES[gi]);
  end

  // Codes are unique, so at most one hit is ever set.
  always_comb begin
    digit_o = 4'd0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hit[i]) begin
        digit_o = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_digit_decoder.sv
// Times key presses against a tick strobe and decodes five-symbol entries into
// digits 0-9. Define MORSE_GAP_TIMEOUT_EN to abort entries after a long idle gap.
module morse_digit_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DASH_TICKS = 3,
  parameter int unsigned GAP_TICKS  = 7,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tick,
  input  logic       key,
  output logic [3:0] user_input,
  output logic       load,
  output logic       error,
  output logic       busy
);

  localparam logic [2:0]       SYMS_FULL = 3'(MORSE_SYMS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic                  sync1_q;
  logic                  key_s;
  logic                  key_prev_q;
  logic [1:0]            fill_q;
  logic                  armed_q, armed_d;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MORSE_SYMS-1:0] pattern_q, pattern_d;
  logic [2:0]            nsym_q, nsym_d;
  logic [3:0]            user_input_q, user_input_d;
  logic                  load_q, load_d;
  logic                  error_q, error_d;

  logic                  key_rise, key_fall, is_dash;
  logic [CNT_W-1:0]      cnt_inc;
  logic [2:0]            nsym_inc;
  logic [3:0]            lut_digit;
  logic                  lut_valid;

  morse_code_lut u_lut (
    .pattern_i (pattern_q),
    .digit_o   (lut_digit),
    .valid_o   (lut_valid)
  );

  // A rise only counts once the key has been seen released after reset or
  // after enable was low, so a key held across either event is ignored.
  assign key_rise = key_s & ~key_prev_q & armed_q;
  assign key_fall = ~key_s & key_prev_q;
  assign is_dash  = (cnt_q >= CNT_W'(DASH_TICKS));
  assign cnt_inc  = cnt_q + 1'b1;
  assign nsym_inc = nsym_q + 3'd1;

`ifndef MORSE_GAP_TIMEOUT_EN
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^CNT_W'(GAP_TICKS);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      key_s        <= 1'b0;
      key_prev_q   <= 1'b0;
      fill_q       <= 2'b00;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pattern_q    <= '0;
      nsym_q       <= 3'd0;
      user_input_q <= 4'd0;
      load_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      sync1_q      <= key;
      key_s        <= sync1_q;
      key_prev_q   <= key_s;
      fill_q       <= {fill_q[0], 1'b1};
      armed_q      <= armed_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pattern_q    <= pattern_d;
      nsym_q       <= nsym_d;
      user_input_q <= user_input_d;
      load_q       <= load_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pattern_d    = pattern_q;
    nsym_d       = nsym_q;
    user_input_d = user_input_q;
    load_d       = 1'b0;
    error_d      = 1'b0;
    armed_d      = armed_q | (fill_q[1] & ~key_s);

    if (!enable) begin
      armed_d   = 1'b0;
      state_d   = ST_IDLE;
      cnt_d     = '0;
      pattern_d = '0;
      nsym_d    = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_rise) begin
            cnt_d   = '0;
            state_d = ST_PRESS;
          end
        end

        ST_PRESS: begin
          // A release takes priority over a coincident tick.
          if (key_fall) begin
            pattern_d = {pattern_q[MORSE_SYMS-2:0], is_dash ? SYM_DASH : SYM_DOT};
            nsym_d    = nsym_inc;
            cnt_d     = '0;
            state_d   = (nsym_inc == SYMS_FULL) ? ST_DECODE : ST_GAP;
          end else if (tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_inc;
          end
        end

        ST_GAP: begin
          if (key_rise) begin
            cnt_d   = '0;
            state_d = ST_PRESS;
          end
`ifdef MORSE_GAP_TIMEOUT_EN
          else if (tick) begin
            if (cnt_inc == CNT_W'(GAP_TICKS)) begin
              error_d   = 1'b1;
              pattern_d = '0;
              nsym_d    = 3'd0;
              cnt_d     = '0;
              state_d   = ST_IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
`endif
        end

        ST_DECODE: begin
          if (lut_valid) begin
            user_input_d = lut_digit;
            load_d       = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          pattern_d = '0;
          nsym_d    = 3'd0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign user_input = user_input_q;
  assign load       = load_q;
  assign error      = error_q;
  assign busy       = (nsym_q != 3'd0) && (nsym_q < SYMS_FULL);

endmodule

// File: tb/tb_morse_digit_decoder.sv
// Self-checking bench for morse_digit_decoder: directed table, hand-written
// corner sequences and randomized entries scored by a tick-counting model.
module tb_morse_digit_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       key = 1'b0;
  logic [3:0] user_input;
  logic       load, error, busy;

  morse_digit_decoder #(.DASH_TICKS(3), .GAP_TICKS(7), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tick       (tick),
    .key        (key),
    .user_input (user_input),
    .load       (load),
    .error      (error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int load_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int cyc = 0, last_load_cyc = -1, rel_cyc = 0;
  int exp_user = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load) begin
      load_cnt      <= load_cnt + 1;
      last_load_cyc <= cyc;
    end
    if (error) err_cnt <= err_cnt + 1;
    if (load && error) overlap_cnt <= overlap_cnt + 1;
  end

  typedef struct {
    logic [4:0] pat;
    int         dot_len;
    int         dash_len;
    bit         exp_load;
    logic [3:0] exp_digit;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  // Reference code for digit d, built from the counting rule.
  function automatic logic [4:0] model_code(input int d);
    logic [4:0] c;
    c = 5'd0;
    for (int p = 0; p < 5; p++) begin
      if (d == 0)      c[4-p] = 1'b1;
      else if (d <= 5) c[4-p] = (p >= d);
      else             c[4-p] = (p < d - 5);
    end
    return c;
  endfunction

  function automatic int model_decode(input logic [4:0] pat);
    for (int d = 0; d < 10; d++) if (model_code(d) == pat) return d;
    return -1;
  endfunction

  // Key high for k cycles, low for g cycles (g >= 2). The press counts the
  // ticks seen while the synchronised key is high, excluding the tick that
  // coincides with the rising edge: drive-cycle positions 4 .. k+2.
  task automatic send_symbol(input int k, input int g, input bit rand_ticks, output bit sym);
    bit t [1:32];
    int cnt;
    for (int i = 1; i <= k + g; i++) t[i] = rand_ticks ? 1'($urandom_range(0, 1)) : 1'b1;
    cnt = 0;
    for (int i = 4; i <= k + 2; i++) cnt += int'(t[i]);
    sym = (cnt >= 3);
    for (int i = 1; i <= k + g; i++) begin
      key  = (i <= k);
      tick = t[i];
      cyc1();
      if (i == k) rel_cyc = cyc;
    end
    tick = 1'b1;
  endtask

  task automatic enter_pattern(input logic [4:0] pat, input int dot_len, input int dash_len);
    bit sy;
    for (int s = 0; s < 5; s++)
      send_symbol(pat[4-s] ? dash_len : dot_len, (s == 4) ? 8 : 3, 1'b0, sy);
  endtask

  initial begin
    int l0, e0;
    bit sy;

    vecs[0] = '{5'b01111, 1, 4, 1'b1, 4'd1};
    vecs[1] = '{5'b11111, 1, 4, 1'b1, 4'd0};
    vecs[2] = '{5'b00000, 2, 5, 1'b1, 4'd5};
    vecs[3] = '{5'b11110, 1, 6, 1'b1, 4'd9};
    vecs[4] = '{5'b01010, 1, 4, 1'b0, 4'd9};
    vecs[5] = '{5'b00111, 3, 4, 1'b1, 4'd2};
    vecs[6] = '{5'b10000, 2, 8, 1'b1, 4'd6};
    vecs[7] = '{5'b00011, 3, 4, 1'b1, 4'd3};
    vecs[8] = '{5'b11000, 1, 4, 1'b1, 4'd7};
    vecs[9] = '{5'b00001, 1, 7, 1'b1, 4'd4};

    // Reset held with the key toggling.
    #1 rst = 1'b0;
    enable = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key = i[0];
      cyc1();
      check("reset_outputs", {28'd0, user_input, load, error, busy}, 32'd0);
    end
    key = 1'b0;
    rst = 1'b1;
    repeat (4) cyc1();
    check("post_reset_strobes", load_cnt + err_cnt, 0);

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      l0 = load_cnt;
      e0 = err_cnt;
      enter_pattern(vecs[v].pat, vecs[v].dot_len, vecs[v].dash_len);
      check($sformatf("tbl%0d_load", v), load_cnt - l0, vecs[v].exp_load);
      check($sformatf("tbl%0d_error", v), err_cnt - e0, !vecs[v].exp_load);
      check($sformatf("tbl%0d_digit", v), user_input, vecs[v].exp_digit);
      check($sformatf("tbl%0d_busy", v), busy, 0);
      if (v == 0) check("load_latency", last_load_cyc - rel_cyc, 4);
      $display("vec %0d pattern %b -> digit %0d load %0d", v, vecs[v].pat, user_input, load_cnt - l0);
    end
    exp_user = 9;

    // Idle gap after two symbols.
    l0 = load_cnt;
    e0 = err_cnt;
    send_symbol(1, 3, 1'b0, sy);
    send_symbol(1, 3, 1'b0, sy);
    check("gap_busy_partial", busy, 1);
    repeat (12) cyc1();
`ifdef MORSE_GAP_TIMEOUT_EN
    check("gap_abort_error", err_cnt - e0, 1);
    check("gap_abort_busy", busy, 0);
    check("gap_abort_load", load_cnt - l0, 0);
`else
    check("gap_hold_error", err_cnt - e0, 0);
    check("gap_hold_busy", busy, 1);
    send_symbol(4, 3, 1'b0, sy);
    send_symbol(4, 3, 1'b0, sy);
    send_symbol(4, 8, 1'b0, sy);
    check("gap_hold_load", load_cnt - l0, 1);
    check("gap_hold_digit", user_input, 2);
    exp_user = 2;
`endif
    $display("gap sequence done: errors %0d loads %0d", err_cnt - e0, load_cnt - l0);

    // Enable dropped after three symbols.
    l0 = load_cnt;
    e0 = err_cnt;
    for (int s = 0; s < 3; s++) send_symbol(4, 3, 1'b0, sy);
    enable = 1'b0;
    repeat (4) cyc1();
    check("en_low_busy", busy, 0);
    enable = 1'b1;
    repeat (2) cyc1();
    enter_pattern(5'b00011, 1, 4);
    check("en_resume_load", load_cnt - l0, 1);
    check("en_resume_error", err_cnt - e0, 0);
    check("en_resume_digit", user_input, 3);
    $display("enable disruption: digit %0d", user_input);

    // Key held while enable rises.
    l0 = load_cnt;
    e0 = err_cnt;
    key = 1'b1;
    enable = 1'b0;
    repeat (4) cyc1();
    enable = 1'b1;
    repeat (6) cyc1();
    key = 1'b0;
    repeat (4) cyc1();
    enter_pattern(5'b11100, 1, 4);
    check("held_key_load", load_cnt - l0, 1);
    check("held_key_error", err_cnt - e0, 0);
    check("held_key_digit", user_input, 8);
    $display("held key at enable: digit %0d", user_input);

    // Reset mid-press, key still held across reset release.
    l0 = load_cnt;
    e0 = err_cnt;
    send_symbol(1, 3, 1'b0, sy);
    key = 1'b1;
    repeat (3) cyc1();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc1();
      check("rst_press_outputs", {28'd0, user_input, load, error, busy}, 32'd0);
    end
    rst = 1'b1;
    repeat (5) cyc1();
    key = 1'b0;
    repeat (4) cyc1();
    check("rst_press_strobes", (load_cnt - l0) + (err_cnt - e0), 0);
    check("rst_press_busy", busy, 0);
    enter_pattern(5'b00011, 2, 5);
    check("rst_after_load", load_cnt - l0, 1);
    check("rst_after_digit", user_input, 3);
    exp_user = 3;
    $display("reset mid-press: digit %0d", user_input);

    // Randomized entries.
    for (int it = 0; it < 30; it++) begin
      bit targeted;
      logic [4:0] want, got;
      int d, k, g;
      targeted = 1'($urandom_range(0, 1));
      if (targeted) want = model_code(int'($urandom_range(0, 9)));
      else          want = 5'($urandom);
      l0 = load_cnt;
      e0 = err_cnt;
      got = 5'd0;
      for (int s = 0; s < 5; s++) begin
        k = want[4-s] ? int'($urandom_range(4, 8)) : int'($urandom_range(1, 3));
        g = (s == 4) ? 8 : int'($urandom_range(2, 6));
        send_symbol(k, g, !targeted, sy);
        got[4-s] = sy;
      end
      d = model_decode(got);
      if (d >= 0) exp_user = d;
      check($sformatf("rnd%0d_load", it), load_cnt - l0, (d >= 0) ? 1 : 0);
      check($sformatf("rnd%0d_error", it), err_cnt - e0, (d >= 0) ? 0 : 1);
      check($sformatf("rnd%0d_digit", it), user_input, exp_user);
      $display("rnd %0d pattern %b -> model %0d dut %0d", it, got, d, user_input);
    end

    check("load_error_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/morse_digit_decoder.md
MORSE_DIGIT_DECODER -- requirements
Module: morse_digit_decoder

Interface
REQ-001 The block SHALL have parameter DASH_TICKS, default 3, giving the minimum press length in ticks that is classified as a dash.
REQ-002 The block SHALL have parameter GAP_TICKS, default 7, giving the released-key idle length in ticks that aborts a partial entry.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the tick counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, with all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port enable, input, 1 bit: decoding allowed; low clears entry.
REQ-007 The block SHALL have port tick, input, 1 bit: single-cycle timebase strobe.
REQ-008 The block SHALL have port key, input, 1 bit: raw Morse key, active-high, asynchronous to clk.
REQ-009 The block SHALL have port user_input, output, 4 bits: last decoded digit 0-9.
REQ-010 The block SHALL have port load, output, 1 bit: one-cycle strobe, valid new user_input.
REQ-011 The block SHALL have port error, output, 1 bit: one-cycle strobe, invalid pattern or gap abort.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a partial entry is held (1-4 symbols).

Function
REQ-013 The block SHALL pass key through a 2-flop synchronizer, key_s, before any use.
REQ-014 The block SHALL implement FSM states IDLE, PRESS, GAP and DECODE.
REQ-015 In IDLE or GAP, key_s rising SHALL clear the tick counter and enter PRESS.
REQ-016 In PRESS, each tick SHALL increment the counter, saturating at all-ones.
REQ-017 When key_s falls in PRESS, the block SHALL shift one symbol into a 5-bit pattern register at the LSB: dash = 1 if count >= DASH_TICKS, else dot = 0.
REQ-018 On that falling edge the block SHALL increment the symbol count (0-5) and clear the counter.
REQ-019 When a symbol completes, the FSM SHALL enter DECODE if the symbol count is now 5, otherwise GAP.
REQ-020 The pattern SHALL be read with the first symbol at bit 4. Valid codes: 0 = 11111; d = 1..5 is d dots then dashes (1 = 01111, ..., 5 = 00000); d = 6..9 is (d-5) dashes then dots (6 = 10000, ..., 9 = 11110).
REQ-021 In DECODE with a valid pattern, the block SHALL register user_input and pulse load for one cycle, exactly 1 cycle after the fifth release is registered.
REQ-022 In DECODE with an invalid pattern, the block SHALL pulse error for one cycle and leave user_input unchanged.
REQ-023 DECODE SHALL clear the pattern and symbol count, then return to IDLE after one cycle.
REQ-024 In GAP, each tick SHALL increment the counter; when it reaches GAP_TICKS, the block SHALL act per REQ-034.
REQ-025 enable low SHALL force IDLE, clear pattern, count and counter, and suppress load and error, while holding user_input.
REQ-026 A key still held when enable rises SHALL be ignored until it is released.
REQ-027 tick and a key_s edge in the same cycle: the edge SHALL take priority, and that tick SHALL not be counted.
REQ-028 load and error SHALL never be asserted in the same cycle.

Reset
REQ-029 When rst = 0, the block SHALL asynchronously force: state IDLE, user_input = 0, load = 0, error = 0, busy = 0, pattern = 0, symbol count = 0, counter = 0, synchronizer = 0.
REQ-030 Reset asserted mid-PRESS or mid-GAP SHALL discard the partial entry without any strobe.
REQ-031 After rst is released, the block SHALL require a fresh key rising edge to start an entry.

Configuration
REQ-032 The block SHALL use macro MORSE_GAP_TIMEOUT_EN to select gap-abort behaviour.
REQ-033 With MORSE_GAP_TIMEOUT_EN defined, the GAP-timeout abort SHALL be active.
REQ-034 On abort, the block SHALL pulse error for one cycle, clear pattern, count and counter, and go to IDLE.
REQ-035 With MORSE_GAP_TIMEOUT_EN undefined, the block SHALL hold a partial entry in GAP indefinitely, and the GAP counter SHALL be absent.

Structure
REQ-036 Shared package morse_pkg SHALL hold: the FSM state encoding, SYM_DOT = 0, SYM_DASH = 1, MORSE_SYMS = 5, and the ten valid 5-bit digit codes.
REQ-037 The block SHALL have sub-module morse_code_lut: combinational, 5-bit pattern in, 4-bit digit plus valid out; it is the only place the code table is applied.

Verification
REQ-038 Reset check: rst low with key toggling -> user_input = 0, load = 0, error = 0, busy = 0 throughout.
REQ-039 Valid digit 1: tick every cycle; press 1 tick, then 4 presses of 4 ticks (.----) -> user_input = 1 and a single load pulse 1 cycle after the last release.
REQ-040 Valid digits 0/5/9: enter 11111, then 00000, then 11110 -> user_input = 0, then 5, then 9, one load pulse each.
REQ-041 Invalid pattern: enter .-.-. (01010) -> one error pulse, no load, user_input holds 9.
REQ-042 Gap abort: 2 symbols then 7 idle ticks -> error pulse and busy drops with macro defined; with macro undefined, no error, busy stays 1, and 3 more symbols complete the digit.
REQ-043 Mid-entry disruption: enable low after 3 symbols, then high, then a full 5-symbol digit -> only the new digit decoded; rst during PRESS -> no strobe and all outputs 0.
